// File: rtl/qoi_types.sv
// Shared QOI decoder types, opcode constants and the running-index hash.
package qoi_types;

  typedef logic [7:0]  byte_t;
  typedef logic [29:0] size_t;
  typedef logic [5:0]  index_t;

  typedef struct packed {
    byte_t a;
    byte_t b;
    byte_t g;
    byte_t r;
  } pixel_t;

  typedef enum logic [2:0] {OP_RGB, OP_RGBA, OP_INDEX, OP_DIFF, OP_LUMA, OP_RUN} op_t;

  typedef enum logic [2:0] {S_IDLE, S_OP, S_ARG, S_RUN, S_DONE} state_t;

  localparam byte_t QOI_OP_INDEX = 8'h00;
  localparam byte_t QOI_OP_DIFF  = 8'h40;
  localparam byte_t QOI_OP_LUMA  = 8'h80;
  localparam byte_t QOI_OP_RUN   = 8'hc0;
  localparam byte_t QOI_OP_RGB   = 8'hfe;
  localparam byte_t QOI_OP_RGBA  = 8'hff;
  localparam byte_t QOI_MASK_2   = 8'hc0;

  // The two 8-bit tags overlap the RUN tag, so they are matched first.
  function automatic op_t qoi_decode_op(input byte_t b);
    op_t op;
    if (b == QOI_OP_RGB) begin
      op = OP_RGB;
    end else if (b == QOI_OP_RGBA) begin
      op = OP_RGBA;
    end else begin
      case (b & QOI_MASK_2)
        QOI_OP_INDEX: op = OP_INDEX;
        QOI_OP_DIFF:  op = OP_DIFF;
        QOI_OP_LUMA:  op = OP_LUMA;
        default:      op = OP_RUN;
      endcase
    end
    return op;
  endfunction

  // Only the low 6 bits of each channel can affect a mod-64 result.
  function automatic index_t qoi_hash(input pixel_t px);
    return index_t'(px.r[5:0] * 6'd3 + px.g[5:0] * 6'd5 +
                    px.b[5:0] * 6'd7 + px.a[5:0] * 6'd11);
  endfunction

endpackage

// File: rtl/qoi_index_ram.sv
// 64-entry running pixel index: async read, sync write, sync clear-all.
module qoi_index_ram (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [64];

  // Clear wins over a same-cycle write so a restart always sees an empty index.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qoi_decoder_core.sv
// QOI chunk-stream decoder: bytes in, RGBA pixels out, stops after a pixel count.
//
// state  | meaning
// IDLE   | waiting for i_start
// OP     | expecting an op byte (or draining the final pixel)
// ARG    | collecting RGB/RGBA/LUMA argument bytes
// RUN    | repeating the previous pixel
// DONE   | one cycle after the last pixel handshake
module qoi_decoder_core
  import qoi_types::*;
#(
  parameter logic [7:0] ALPHA_INIT = 8'hff
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [29:0] i_pixel_count,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [31:0] o_pixel,
  output logic        o_pixel_valid,
  input  logic        i_pixel_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam pixel_t PREV_INIT = {ALPHA_INIT, 24'h000000};

  state_t     state, state_next;
  op_t        op_kind, op_next, cur_op;
  logic [2:0] arg_left, arg_left_next;
  logic [5:0] run_left, run_next;
  logic [23:0] arg_sr;
  pixel_t     prev, pix, px_new, idx_px;
  pixel_t     diff_px, luma_px, rgb_px, rgba_px;
  byte_t      luma_dg;
  size_t      to_load, to_emit;
  logic       pix_valid, zero_done;
  logic       adv, hs, final_hs, take, load, shift;

  // to_load counts pixels not yet produced, to_emit those not yet handed off;
  // gating on to_load keeps bytes after the last pixel in the FIFO.
  assign adv          = !pix_valid || i_pixel_ready;
  assign hs           = pix_valid && i_pixel_ready;
  assign final_hs     = hs && (to_emit == 30'd1);
  assign o_byte_ready = (state == S_OP || state == S_ARG) && adv && (to_load != '0);
  assign take         = o_byte_ready && i_byte_valid;
  assign cur_op       = qoi_decode_op(i_byte);

  assign o_pixel       = pix;
  assign o_pixel_valid = pix_valid;
  assign o_busy        = (state == S_OP) || (state == S_ARG) || (state == S_RUN);
  assign o_done        = final_hs || zero_done;

  qoi_index_ram u_index (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (i_start),
    .we    (load),
    .waddr (qoi_hash(px_new)),
    .wdata (px_new),
    .raddr (i_byte[5:0]),
    .rdata (idx_px)
  );

  // Candidate pixels for every op, built from prev, buffered args and the live byte.
  always_comb begin
    diff_px   = prev;
    diff_px.r = prev.r + {6'd0, i_byte[5:4]} - 8'd2;
    diff_px.g = prev.g + {6'd0, i_byte[3:2]} - 8'd2;
    diff_px.b = prev.b + {6'd0, i_byte[1:0]} - 8'd2;
    luma_dg   = {2'd0, arg_sr[5:0]} - 8'd32;
    luma_px   = prev;
    luma_px.r = prev.r + luma_dg + {4'd0, i_byte[7:4]} - 8'd8;
    luma_px.g = prev.g + luma_dg;
    luma_px.b = prev.b + luma_dg + {4'd0, i_byte[3:0]} - 8'd8;
    rgb_px    = prev;
    rgb_px.r  = arg_sr[15:8];
    rgb_px.g  = arg_sr[7:0];
    rgb_px.b  = i_byte;
    rgba_px   = {i_byte, arg_sr[7:0], arg_sr[15:8], arg_sr[23:16]};
  end

  // Next-state and pixel-load decisions.
  always_comb begin
    state_next    = state;
    load          = 1'b0;
    shift         = 1'b0;
    px_new        = prev;
    op_next       = op_kind;
    arg_left_next = arg_left;
    run_next      = run_left;
    case (state)
      S_OP: begin
        if (take) begin
          case (cur_op)
            OP_RGB:   begin op_next = OP_RGB;  arg_left_next = 3'd3; shift = 1'b1; state_next = S_ARG; end
            OP_RGBA:  begin op_next = OP_RGBA; arg_left_next = 3'd4; shift = 1'b1; state_next = S_ARG; end
            OP_LUMA:  begin op_next = OP_LUMA; arg_left_next = 3'd1; shift = 1'b1; state_next = S_ARG; end
            OP_INDEX: begin load = 1'b1; px_new = idx_px; end
            OP_DIFF:  begin load = 1'b1; px_new = diff_px; end
            default: begin
              load     = 1'b1;
              run_next = i_byte[5:0];
              if (i_byte[5:0] != 6'd0 && to_load > 30'd1) state_next = S_RUN;
            end
          endcase
        end
      end
      S_ARG: begin
        if (take) begin
          if (arg_left == 3'd1) begin
            load       = 1'b1;
            state_next = S_OP;
            case (op_kind)
              OP_RGB:  px_new = rgb_px;
              OP_RGBA: px_new = rgba_px;
              OP_LUMA: px_new = luma_px;
              default: px_new = prev;
            endcase
          end else begin
            shift         = 1'b1;
            arg_left_next = arg_left - 3'd1;
          end
        end
      end
      S_RUN: begin
        if (adv) begin
          load     = 1'b1;
          run_next = run_left - 6'd1;
          if (run_left == 6'd1 || to_load == 30'd1) state_next = S_OP;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = state;
    endcase
    if (final_hs) state_next = S_DONE;
    if (i_start) begin
      load       = 1'b0;
      shift      = 1'b0;
      state_next = (i_pixel_count == '0) ? S_DONE : S_OP;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Datapath: pixel output, previous pixel, counters and argument buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix       <= '0;
      pix_valid <= 1'b0;
      prev      <= PREV_INIT;
      to_load   <= '0;
      to_emit   <= '0;
      zero_done <= 1'b0;
      op_kind   <= OP_INDEX;
      arg_left  <= '0;
      run_left  <= '0;
      arg_sr    <= '0;
    end else if (i_start) begin
      pix_valid <= 1'b0;
      prev      <= PREV_INIT;
      to_load   <= i_pixel_count;
      to_emit   <= i_pixel_count;
      zero_done <= (i_pixel_count == '0);
      arg_left  <= '0;
      run_left  <= '0;
    end else begin
      zero_done <= 1'b0;
      op_kind   <= op_next;
      arg_left  <= arg_left_next;
      run_left  <= run_next;
      if (shift) arg_sr <= {arg_sr[15:0], i_byte};
      if (load) begin
        pix     <= px_new;
        prev    <= px_new;
        to_load <= to_load - 30'd1;
      end
      if (hs) to_emit <= to_emit - 30'd1;
      pix_valid <= load || (pix_valid && !i_pixel_ready);
    end
  end

endmodule
